// File: rtl/cfu_mac_sequencer.sv
// CFU command initiator: SET_OFFSET, CLEAR, then LEN MAC commands fed from an
// operand stream; the CFU's final accumulator is returned on a result handshake.
module cfu_mac_sequencer #(
    parameter int unsigned LEN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      start_offset,
    input  logic [LEN_W-1:0] start_len,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_filter,
    input  logic [31:0]      in_act,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [9:0]       cmd_payload_function_id,
    output logic [31:0]      cmd_payload_inputs_0,
    output logic [31:0]      cmd_payload_inputs_1,
    input  logic             rsp_valid,
    output logic             rsp_ready,
    input  logic [31:0]      rsp_payload_outputs_0
);

    localparam logic [9:0] FID_SET_OFFSET = {7'd2, 3'd3};
    localparam logic [9:0] FID_CLEAR      = {7'd1, 3'd3};
    localparam logic [9:0] FID_MAC        = {7'd0, 3'd3};

    typedef enum logic [3:0] {
        IDLE,
        OFS_CMD,
        OFS_RSP,
        CLR_CMD,
        CLR_RSP,
        MAC_FETCH,
        MAC_CMD,
        MAC_RSP,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic             busy_q, busy_d;
    logic             cmd_valid_q, cmd_valid_d;
    logic [9:0]       fid_q, fid_d;
    logic [31:0]      in0_q, in0_d;
    logic [31:0]      in1_q, in1_d;
    logic             res_valid_q, res_valid_d;
    logic [31:0]      res_data_q, res_data_d;

    // One bit wider than len so the final-command test cannot alias on wrap.
    logic [LEN_W:0]   count_inc;
    assign count_inc = {1'b0, count_q} + {{LEN_W{1'b0}}, 1'b1};

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        count_d     = count_q;
        cmd_valid_d = cmd_valid_q;
        fid_d       = fid_q;
        in0_d       = in0_q;
        in1_d       = in1_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    len_d       = start_len;
                    count_d     = '0;
                    fid_d       = FID_SET_OFFSET;
                    in0_d       = start_offset;
                    in1_d       = '0;
                    cmd_valid_d = 1'b1;
                    state_d     = OFS_CMD;
                end
            end
            OFS_CMD: begin
                if (cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    state_d     = OFS_RSP;
                end
            end
            OFS_RSP: begin
                if (rsp_valid) begin
                    fid_d       = FID_CLEAR;
                    in0_d       = '0;
                    in1_d       = '0;
                    cmd_valid_d = 1'b1;
                    state_d     = CLR_CMD;
                end
            end
            CLR_CMD: begin
                if (cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    state_d     = CLR_RSP;
                end
            end
            CLR_RSP: begin
                if (rsp_valid) begin
                    if (len_q == '0) begin
                        res_data_d  = rsp_payload_outputs_0;
                        res_valid_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        state_d = MAC_FETCH;
                    end
                end
            end
            MAC_FETCH: begin
                if (in_valid) begin
                    fid_d       = FID_MAC;
                    in0_d       = in_filter;
                    in1_d       = in_act;
                    cmd_valid_d = 1'b1;
                    state_d     = MAC_CMD;
                end
            end
            MAC_CMD: begin
                if (cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    state_d     = MAC_RSP;
                end
            end
            MAC_RSP: begin
                if (rsp_valid) begin
                    count_d = count_inc[LEN_W-1:0];
                    if (count_inc == {1'b0, len_q}) begin
                        res_data_d  = rsp_payload_outputs_0;
                        res_valid_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        state_d = MAC_FETCH;
                    end
                end
            end
            DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            len_q       <= '0;
            count_q     <= '0;
            busy_q      <= 1'b0;
            cmd_valid_q <= 1'b0;
            fid_q       <= '0;
            in0_q       <= '0;
            in1_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            count_q     <= count_d;
            busy_q      <= busy_d;
            cmd_valid_q <= cmd_valid_d;
            fid_q       <= fid_d;
            in0_q       <= in0_d;
            in1_q       <= in1_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

    assign busy                    = busy_q;
    assign cmd_valid               = cmd_valid_q;
    assign cmd_payload_function_id = fid_q;
    assign cmd_payload_inputs_0    = in0_q;
    assign cmd_payload_inputs_1    = in1_q;
    assign res_valid               = res_valid_q;
    assign res_data                = res_data_q;
    assign in_ready                = (state_q == MAC_FETCH);
    assign rsp_ready               = (state_q == OFS_RSP) || (state_q == CLR_RSP) || (state_q == MAC_RSP);

endmodule

// File: tb/tb_cfu_mac_sequencer.sv
// Bench for cfu_mac_sequencer: behavioural CFU, operand source and result sink,
// with a command scoreboard and dot-product model checked every cycle.
module tb_cfu_mac_sequencer;

    localparam int LEN_W = 16;
    localparam logic [9:0] ID_SET = 10'd19;
    localparam logic [9:0] ID_CLR = 10'd11;
    localparam logic [9:0] ID_MAC = 10'd3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [31:0]      start_offset = '0;
    logic [LEN_W-1:0] start_len = '0;
    logic             busy;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_filter = '0;
    logic [31:0]      in_act = '0;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [31:0]      res_data;
    logic             cmd_valid;
    logic             cmd_ready = 1'b0;
    logic [9:0]       cmd_payload_function_id;
    logic [31:0]      cmd_payload_inputs_0;
    logic [31:0]      cmd_payload_inputs_1;
    logic             rsp_valid = 1'b0;
    logic             rsp_ready;
    logic [31:0]      rsp_payload_outputs_0 = '0;

    cfu_mac_sequencer #(.LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset), .start(start), .start_offset(start_offset),
        .start_len(start_len), .busy(busy), .in_valid(in_valid), .in_ready(in_ready),
        .in_filter(in_filter), .in_act(in_act), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready), .cmd_payload_function_id(cmd_payload_function_id),
        .cmd_payload_inputs_0(cmd_payload_inputs_0), .cmd_payload_inputs_1(cmd_payload_inputs_1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_payload_outputs_0(rsp_payload_outputs_0)
    );

    typedef struct packed {
        logic [9:0]  id;
        logic [31:0] a0;
        logic [31:0] a1;
    } cmd_t;

    cmd_t        exp_q[$];
    logic [63:0] src_q[$];
    int          errors = 0;
    int          checks = 0;

    // Environment knobs
    logic hold_rand = 1'b0;
    int   cmd_hold = 0, in_hold = 0, res_hold = 0, lat_max = 1;

    // Shared between checker (negedge) and environment/main (after posedge)
    logic        f_cmd = 0, f_rsp = 0, f_in = 0, f_res = 0;
    logic [9:0]  s_id = '0;
    logic [31:0] s_a0 = '0, s_a1 = '0;
    int          outstanding = 0, res_count = 0, mac_fires = 0, in_ready_cycles = 0;
    logic [31:0] exp_res = '0, last_res = '0;
    int          in_wait = 0;

    task automatic chk(input string name, input logic ok, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Sum over the four byte lanes of filter * (activation + offset), 32-bit wrap.
    function automatic logic [31:0] word_dot(logic [31:0] ofs, logic [31:0] f, logic [31:0] a);
        logic signed [31:0] s;
        logic signed [31:0] fb, ab;
        s = '0;
        for (int i = 0; i < 4; i++) begin
            fb = 32'($signed(f[8*i +: 8]));
            ab = 32'($signed(a[8*i +: 8]));
            s  = s + fb * (ab + $signed(ofs));
        end
        return s;
    endfunction

    function automatic int reload(int h);
        return hold_rand ? int'($urandom_range(0, h)) : h;
    endfunction

    // ---------------- checker ----------------
    logic        p_cmd_stall = 0, p_res_stall = 0;
    logic [9:0]  p_id = '0;
    logic [31:0] p_a0 = '0, p_a1 = '0, p_res = '0;

    initial forever begin
        @(negedge clk);
        if (reset) begin
            f_cmd = 0; f_rsp = 0; f_in = 0; f_res = 0;
            p_cmd_stall = 0; p_res_stall = 0;
            outstanding = 0;
            exp_q.delete();
        end else begin
            f_cmd = cmd_valid & cmd_ready;
            f_rsp = rsp_valid & rsp_ready;
            f_in  = in_valid & in_ready;
            f_res = res_valid & res_ready;

            if (!busy)
                chk("idle_quiet", {cmd_valid, res_valid, in_ready, rsp_ready} == 4'b0,
                    64'({cmd_valid, res_valid, in_ready, rsp_ready}), 64'(0));
            if (in_ready) begin
                in_ready_cycles++;
                chk("in_ready_phase",
                    ((exp_q.size() > 0) ? (exp_q[0].id == ID_MAC) : 1'b0) && outstanding == 0
                        && !cmd_valid && busy,
                    64'(exp_q.size()), 64'(outstanding));
            end
            if (rsp_ready)
                chk("rsp_ready_outstanding", outstanding == 1 && !cmd_valid && !in_ready,
                    64'(outstanding), 64'(1));
            if (p_cmd_stall) begin
                chk("cmd_hold_valid", cmd_valid, 64'(cmd_valid), 64'(1));
                chk("cmd_hold_id", cmd_payload_function_id == p_id, 64'(cmd_payload_function_id), 64'(p_id));
                chk("cmd_hold_in0", cmd_payload_inputs_0 == p_a0, 64'(cmd_payload_inputs_0), 64'(p_a0));
                chk("cmd_hold_in1", cmd_payload_inputs_1 == p_a1, 64'(cmd_payload_inputs_1), 64'(p_a1));
            end
            if (p_res_stall) begin
                chk("res_hold_valid", res_valid, 64'(res_valid), 64'(1));
                chk("res_hold_data", res_data == p_res, 64'(res_data), 64'(p_res));
            end
            if (f_cmd) begin
                cmd_t e;
                chk("cmd_single_outstanding", outstanding == 0, 64'(outstanding), 64'(0));
                chk("cmd_expected", exp_q.size() > 0, 64'(cmd_payload_function_id), 64'(0));
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("cmd_id", cmd_payload_function_id == e.id, 64'(cmd_payload_function_id), 64'(e.id));
                    chk("cmd_in0", cmd_payload_inputs_0 == e.a0, 64'(cmd_payload_inputs_0), 64'(e.a0));
                    chk("cmd_in1", cmd_payload_inputs_1 == e.a1, 64'(cmd_payload_inputs_1), 64'(e.a1));
                end
                if (cmd_payload_function_id == ID_MAC) mac_fires++;
                outstanding++;
                s_id = cmd_payload_function_id;
                s_a0 = cmd_payload_inputs_0;
                s_a1 = cmd_payload_inputs_1;
            end
            if (f_rsp) begin
                chk("rsp_matches_cmd", outstanding == 1, 64'(outstanding), 64'(1));
                outstanding--;
            end
            if (f_res) begin
                chk("res_data", res_data == exp_res, 64'(res_data), 64'(exp_res));
                chk("res_all_cmds_issued", exp_q.size() == 0, 64'(exp_q.size()), 64'(0));
                last_res = res_data;
                res_count++;
            end
            p_cmd_stall = cmd_valid & ~cmd_ready;
            p_id = cmd_payload_function_id;
            p_a0 = cmd_payload_inputs_0;
            p_a1 = cmd_payload_inputs_1;
            p_res_stall = res_valid & ~res_ready;
            p_res = res_data;
        end
    end

    // ---------------- environment: CFU, operand source, result sink ----------------
    logic [31:0] cfu_ofs = '0, cfu_acc = '0, pend_data = '0;
    logic        pend = 1'b0;
    int          rsp_cnt = 0, cmd_wait = 0, res_wait = 0;

    initial forever begin
        @(posedge clk);
        #1;
        if (reset) begin
            rsp_valid = 0; pend = 0; cfu_acc = '0; cfu_ofs = '0;
            cmd_ready = 0; res_ready = 0; in_valid = 0; in_wait = 0;
            src_q.delete();
        end else begin
            if (f_rsp) begin
                rsp_valid = 0;
                pend = 0;
            end
            if (f_cmd) begin
                case (s_id)
                    ID_SET: begin cfu_ofs = s_a0; pend_data = $urandom; end
                    ID_CLR: begin cfu_acc = '0; pend_data = '0; end
                    ID_MAC: begin cfu_acc = cfu_acc + word_dot(cfu_ofs, s_a0, s_a1); pend_data = cfu_acc; end
                    default: pend_data = $urandom;
                endcase
                pend = 1;
                rsp_cnt = hold_rand ? int'($urandom_range(0, lat_max - 1)) : lat_max - 1;
            end
            if (pend && !rsp_valid) begin
                if (rsp_cnt == 0) begin
                    rsp_valid = 1;
                    rsp_payload_outputs_0 = pend_data;
                end else rsp_cnt--;
            end
            if (!rsp_valid) rsp_payload_outputs_0 = $urandom;

            if (f_in) begin
                void'(src_q.pop_front());
                in_wait = reload(in_hold);
            end
            in_valid = (src_q.size() > 0) && (in_wait == 0);
            if (src_q.size() > 0) {in_filter, in_act} = src_q[0];
            else begin in_filter = $urandom; in_act = $urandom; end
            if (in_ready && in_wait > 0) in_wait--;

            if (cmd_valid) begin
                if (cmd_wait > 0) begin cmd_ready = 0; cmd_wait--; end
                else cmd_ready = 1;
            end else begin
                cmd_ready = 1'($urandom_range(0, 1));
                cmd_wait = reload(cmd_hold);
            end

            if (res_valid) begin
                if (res_wait > 0) begin res_ready = 0; res_wait--; end
                else res_ready = 1;
            end else begin
                res_ready = 1'($urandom_range(0, 1));
                res_wait = reload(res_hold);
            end
        end
    end

    // ---------------- main sequence ----------------
    logic [31:0] job_f[16];
    logic [31:0] job_a[16];
    int          rc0;

    task automatic step();
        @(posedge clk);
        #3;
    endtask

    task automatic launch(input logic [31:0] ofs, input int len);
        exp_q.push_back('{ID_SET, ofs, 32'd0});
        exp_q.push_back('{ID_CLR, 32'd0, 32'd0});
        exp_res = '0;
        for (int i = 0; i < len; i++) begin
            src_q.push_back({job_f[i], job_a[i]});
            exp_q.push_back('{ID_MAC, job_f[i], job_a[i]});
            exp_res = exp_res + word_dot(ofs, job_f[i], job_a[i]);
        end
        in_wait = reload(in_hold);
        rc0 = res_count;
        start = 1; start_offset = ofs; start_len = LEN_W'(len);
        step();
        start = 0; start_offset = $urandom; start_len = LEN_W'($urandom);
    endtask

    task automatic wait_result(output logic [31:0] r);
        int n;
        n = 0;
        while (res_count == rc0 && n < 3000) begin
            step();
            n++;
            if (hold_rand && $urandom_range(0, 7) == 0) begin
                start = 1; start_offset = $urandom; start_len = LEN_W'($urandom_range(1, 9));
            end else start = 0;
        end
        start = 0;
        chk("result_arrives", res_count != rc0, 64'(n), 64'(3000));
        if (res_count == rc0) begin
            reset = 1; step(); step(); reset = 0;
        end
        r = last_res;
        step();
    endtask

    initial begin
        logic [31:0] r;
        int n;
        repeat (3) step();
        reset = 0;
        step();
        chk("rst_busy", busy == 0, 64'(busy), 64'(0));
        chk("rst_cmd_valid", cmd_valid == 0, 64'(cmd_valid), 64'(0));
        chk("rst_res_valid", res_valid == 0, 64'(res_valid), 64'(0));
        chk("rst_in_ready", in_ready == 0, 64'(in_ready), 64'(0));
        chk("rst_rsp_ready", rsp_ready == 0, 64'(rsp_ready), 64'(0));
        chk("rst_res_data", res_data == 0, 64'(res_data), 64'(0));
        chk("rst_payload", {cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1} == '0,
            64'(cmd_payload_inputs_0), 64'(0));

        // Operand stream with no start must not be consumed
        for (int i = 0; i < 3; i++) src_q.push_back({$urandom, $urandom});
        repeat (10) step();
        chk("idle_stream_ignored", src_q.size() == 3, 64'(src_q.size()), 64'(3));
        src_q.delete();

        // offset=128, two words of filter 1s / act 0 -> 1024
        job_f[0] = 32'h01010101; job_a[0] = 32'h0;
        job_f[1] = 32'h01010101; job_a[1] = 32'h0;
        launch(32'd128, 2);
        chk("model_pin_1024", exp_res == 32'd1024, 64'(exp_res), 64'(1024));
        wait_result(r);
        chk("dir_len2_result", r == 32'd1024, 64'(r), 64'(1024));

        // offset=128, filter 2s, act -1 -> 4*2*127
        job_f[0] = 32'h02020202; job_a[0] = 32'hFFFFFFFF;
        launch(32'd128, 1);
        chk("model_pin_1016", exp_res == 32'd1016, 64'(exp_res), 64'(1016));
        wait_result(r);
        chk("dir_len1_result", r == 32'd1016, 64'(r), 64'(1016));

        // len=0: SET_OFFSET and CLEAR only
        in_ready_cycles = 0;
        launch(32'd5, 0);
        wait_result(r);
        chk("len0_result", r == 32'd0, 64'(r), 64'(0));
        chk("len0_no_in_ready", in_ready_cycles == 0, 64'(in_ready_cycles), 64'(0));

        // Backpressure on every interface
        cmd_hold = 5; in_hold = 3; res_hold = 4; lat_max = 2;
        for (int i = 0; i < 3; i++) begin job_f[i] = $urandom; job_a[i] = $urandom; end
        launch($urandom, 3);
        wait_result(r);
        chk("bp_result", r == exp_res, 64'(r), 64'(exp_res));

        // Abort in MAC_RSP of a len=4 job, then a fresh len=1 job
        cmd_hold = 0; in_hold = 0; res_hold = 0; lat_max = 4;
        for (int i = 0; i < 4; i++) begin job_f[i] = $urandom; job_a[i] = $urandom; end
        mac_fires = 0;
        launch(32'd77, 4);
        n = 0;
        while (!(mac_fires >= 1 && rsp_ready) && n < 200) begin step(); n++; end
        chk("abort_reach_mac_rsp", mac_fires >= 1 && rsp_ready, 64'(mac_fires), 64'(1));
        reset = 1; step(); step(); reset = 0;
        step();
        chk("abort_busy", busy == 0, 64'(busy), 64'(0));
        chk("abort_cmd_valid", cmd_valid == 0, 64'(cmd_valid), 64'(0));
        chk("abort_res_data", res_data == 0, 64'(res_data), 64'(0));
        lat_max = 1;
        job_f[0] = 32'h02020202; job_a[0] = 32'hFFFFFFFF;
        launch(32'd128, 1);
        wait_result(r);
        chk("after_abort_result", r == 32'd1016, 64'(r), 64'(1016));

        // Randomized jobs
        hold_rand = 1; cmd_hold = 2; in_hold = 2; res_hold = 2; lat_max = 3;
        for (int j = 0; j < 40; j++) begin
            int len;
            len = int'($urandom_range(0, 6));
            for (int i = 0; i < len; i++) begin job_f[i] = $urandom; job_a[i] = $urandom; end
            launch($urandom, len);
            wait_result(r);
            chk("rand_result", r == exp_res, 64'(r), 64'(exp_res));
            repeat ($urandom_range(0, 3)) step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
